// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states,
// character-length encoding and the layout of the per-entry error field.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  localparam int unsigned RERR_FRAME  = 0;
  localparam int unsigned RERR_PARITY = 1;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    logic [2:0] idx;
    case (data_bits)
      DBITS_5: idx = 3'd4;
      DBITS_6: idx = 3'd5;
      DBITS_7: idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and overrun pulse.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     wvalid_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rready_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overrun_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             overrun_q, overrun_d;
  logic             full, push, pop;

  assign rvalid_o  = (level_q != '0);
  assign level_o   = level_q;
  assign overrun_o = overrun_q;
  assign rdata_o   = rvalid_o ? mem_q[rptr_q] : '0;

  always_comb begin
    full      = (level_q == (AW+1)'(DEPTH));
    pop       = rvalid_o && rready_i && !clr_i;
    push      = wvalid_i && (!full || pop) && !clr_i;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    overrun_d = wvalid_i && full && !pop && !clr_i;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with synchroniser, majority-vote mid-bit sampling, parity,
// framing and break detection, feeding a FWFT receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          fifo_clr_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic [1:0]                    data_bits_i,
  input  logic [15:0]                   div_ratio_i,
  input  logic                          rx_i,
  output logic [7:0]                    rdata_o,
  output logic [1:0]                    rerr_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          idle_o,
  output logic                          overrun_o,
  output logic                          break_o
);

  rx_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            div_q, div_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [1:0]             dbits_q, dbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   zero_q, zero_d;
  logic                   push_q, push_d;
  logic [9:0]             push_data_q, push_data_d;
  logic                   brk_q, brk_d;

  logic       rx_s, fall, maj, tick;
  logic [9:0] fifo_rdata;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = hist_q[0] && !rx_s;
  // Vote over the sample cycle and the two cycles before it.
  assign maj     = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign tick    = (cnt_q == 16'd1);
  assign idle_o  = (state_q == ST_IDLE);
  assign break_o = brk_q;
  assign rdata_o = fifo_rdata[7:0];
  assign rerr_o  = fifo_rdata[9:8];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_i};
    hist_d      = {hist_q[0], rx_s};
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    dbits_d     = dbits_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    zero_d      = zero_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    brk_d       = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d   = ST_START;
            cnt_d     = div_ratio_i >> 1;
            div_d     = div_ratio_i;
            dbits_d   = data_bits_i;
            par_en_d  = parity_en_i;
            par_odd_d = parity_odd_i;
            stop2_d   = stop2_i;
            bit_d     = '0;
            shreg_d   = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            zero_d    = 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          if (!tick) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = div_q;
            case (state_q)
              ST_START: begin
                state_d = maj ? ST_IDLE : ST_DATA;
              end
              ST_DATA: begin
                shreg_d[bit_q] = maj;
                zero_d         = zero_q & ~maj;
                if (bit_q == last_bit_idx(dbits_q)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end else begin
                  bit_d = bit_q + 1'b1;
                end
              end
              ST_PARITY: begin
                perr_d  = ((^shreg_q) ^ maj) != par_odd_q;
                zero_d  = zero_q & ~maj;
                state_d = ST_STOP1;
              end
              ST_STOP1: begin
                if (!maj && zero_q) begin
                  brk_d   = 1'b1;
                  state_d = ST_BRK_WAIT;
                end else if (stop2_q) begin
                  ferr_d  = ~maj;
                  state_d = ST_STOP2;
                end else begin
                  push_d                      = 1'b1;
                  push_data_d                 = {2'b00, shreg_q};
                  push_data_d[8+RERR_PARITY]  = perr_q;
                  push_data_d[8+RERR_FRAME]   = ~maj;
                  state_d                     = ST_IDLE;
                end
              end
              ST_STOP2: begin
                push_d                      = 1'b1;
                push_data_d                 = {2'b00, shreg_q};
                push_data_d[8+RERR_PARITY]  = perr_q;
                push_data_d[8+RERR_FRAME]   = ferr_q | ~maj;
                state_d                     = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sync_q      <= '1;
      hist_q      <= '1;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      dbits_q     <= DBITS_8;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      zero_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      dbits_q     <= dbits_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      zero_q      <= zero_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      brk_q       <= brk_d;
    end
  end

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (fifo_clr_i),
    .wvalid_i  (push_q),
    .wdata_i   (push_data_q),
    .rready_i  (rready_i),
    .rdata_o   (fifo_rdata),
    .rvalid_o  (rvalid_o),
    .level_o   (level_o),
    .overrun_o (overrun_o)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised onto rx_i, the
// expected FIFO entry is queued, and entries are compared as they are popped.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV   = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable_i, fifo_clr_i, parity_en_i, parity_odd_i, stop2_i;
  logic [1:0] data_bits_i;
  logic [15:0] div_ratio_i;
  logic       rx_i;
  logic [7:0] rdata_o;
  logic [1:0] rerr_o;
  logic       rvalid_o, rready_i;
  logic [2:0] level_o;
  logic       idle_o, overrun_o, break_o;

  uart_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .fifo_clr_i   (fifo_clr_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .data_bits_i  (data_bits_i),
    .div_ratio_i  (div_ratio_i),
    .rx_i         (rx_i),
    .rdata_o      (rdata_o),
    .rerr_o       (rerr_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i),
    .level_o      (level_o),
    .idle_o       (idle_o),
    .overrun_o    (overrun_o),
    .break_o      (break_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ovr_seen = 0;
  int unsigned brk_seen = 0;
  int unsigned ovr_exp  = 0;
  logic [9:0]  sb [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && overrun_o) ovr_seen++;
    if (rst_ni && break_o)   brk_seen++;
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (DIV) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned nb, input bit pen,
                            input bit pod, input bit pflip, input bit two,
                            input bit s1, input bit s2);
    logic [7:0] dm;
    logic       p;
    logic [9:0] exp;
    dm = '0;
    for (int i = 0; i < int'(nb); i++) dm[i] = d[i];
    p = (^dm) ^ pod ^ pflip;
    @(posedge clk_i);
    #1;
    parity_en_i  = pen;
    parity_odd_i = pod;
    stop2_i      = two;
    data_bits_i  = 2'(nb - 5);
    div_ratio_i  = 16'(DIV);
    drive_bit(1'b0);
    for (int i = 0; i < int'(nb); i++) drive_bit(dm[i]);
    if (pen) drive_bit(p);
    drive_bit(s1);
    if (two) drive_bit(s2);
    drive_bit(1'b1);
    drive_bit(1'b1);
    exp = {pen & pflip, ~s1 | (two & ~s2), dm};
    if (sb.size() < DEPTH) sb.push_back(exp);
    else ovr_exp++;
  endtask

  task automatic send8(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain_check();
    logic [9:0] exp;
    for (int n = 0; n < int'(DEPTH) + 4; n++) begin
      @(negedge clk_i);
      if (!rvalid_o) break;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
        break;
      end
      exp = sb.pop_front();
      check_eq("rdata", 32'(rdata_o), 32'(exp[7:0]));
      check_eq("rerr", 32'(rerr_o), 32'(exp[9:8]));
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
    end
    check_eq("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_level", 32'(level_o), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst_rdata", 32'(rdata_o), 32'd0);
    check_eq("rst_rerr", 32'(rerr_o), 32'd0);
    check_eq("rst_overrun", 32'(overrun_o), 32'd0);
    check_eq("rst_break", 32'(break_o), 32'd0);
    check_eq("rst_idle", 32'(idle_o), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    int unsigned busy;
    busy = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (!idle_o) busy++;
    end
    check_eq(tag, busy, 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int unsigned base, busy;
    bit          seen_busy, seen_idle;
    logic [9:0]  exp;

    rst_ni = 1'b0; rx_i = 1'b1; enable_i = 1'b1; fifo_clr_i = 1'b0; rready_i = 1'b0;
    parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0; data_bits_i = 2'd3;
    div_ratio_i = 16'(DIV);
    repeat (3) @(negedge clk_i);
    check_reset_vals();
    rst_ni = 1'b1;
    check_quiet("no_false_start");

    // 8N1 0xA5
    send8(8'hA5);
    @(negedge clk_i);
    check_eq("a5_level", 32'(level_o), 32'd1);
    drain_check();

    // 7O1 0x35 with wrong parity bit, then other formats and frame errors
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i);
    check_eq("par_rerr", 32'(rerr_o), 32'h2);
    send_frame(8'hF5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_check();

    // 4-cycle glitch while idle
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rx_i = 1'b1;
    seen_busy = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (!idle_o) seen_busy = 1'b1;
    end
    check_eq("glitch_started", 32'(seen_busy), 32'd1);
    check_eq("glitch_idle", 32'(idle_o), 32'd1);
    check_eq("glitch_level", 32'(level_o), 32'd0);

    // Five frames into a depth-4 FIFO with no reads
    base = ovr_seen; ovr_exp = 0;
    send8(8'h11); send8(8'h22); send8(8'h33); send8(8'h44); send8(8'h55);
    @(negedge clk_i);
    check_eq("ovr_level", 32'(level_o), 32'd4);
    check_eq("ovr_pulses", ovr_seen - base, ovr_exp);
    check_eq("ovr_exp_one", ovr_exp, 32'd1);
    drain_check();

    // Full FIFO, pop on the push cycle
    send8(8'h61); send8(8'h62); send8(8'h63); send8(8'h64);
    base = ovr_seen;
    fork
      send8(8'h65);
      begin
        seen_busy = 1'b0; seen_idle = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk_i);
          if (!idle_o) seen_busy = 1'b1;
          else if (seen_busy) begin
            seen_idle = 1'b1;
            break;
          end
        end
        check_eq("pp_frame_done", 32'(seen_idle), 32'd1);
        if (seen_idle) begin
          exp = sb.pop_front();
          check_eq("pp_head", 32'(rdata_o), 32'(exp[7:0]));
          rready_i = 1'b1;
          @(negedge clk_i);
          rready_i = 1'b0;
        end
      end
    join
    @(negedge clk_i);
    check_eq("pp_level", 32'(level_o), 32'd4);
    check_eq("pp_no_ovr", ovr_seen - base, 32'd0);
    drain_check();

    // Break: 12 bit-times low, then a normal frame
    base = brk_seen;
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    repeat (12 * DIV) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (2 * DIV) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("brk_pulses", brk_seen - base, 32'd1);
    check_eq("brk_level", 32'(level_o), 32'd0);
    check_eq("brk_idle", 32'(idle_o), 32'd1);
    send8(8'h5A);
    drain_check();

    // Flush wins over a same-cycle pop
    send8(8'hC3); send8(8'h3C);
    @(negedge clk_i);
    fifo_clr_i = 1'b1; rready_i = 1'b1;
    @(negedge clk_i);
    fifo_clr_i = 1'b0; rready_i = 1'b0;
    check_eq("clr_level", 32'(level_o), 32'd0);
    check_eq("clr_rvalid", 32'(rvalid_o), 32'd0);
    sb.delete();
    send8(8'h96);
    drain_check();

    // Disable mid-frame keeps FIFO contents
    send8(8'h77);
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    repeat (3 * DIV) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("en_busy", 32'(idle_o), 32'd0);
    enable_i = 1'b0;
    @(negedge clk_i);
    check_eq("en_idle", 32'(idle_o), 32'd1);
    rx_i = 1'b1;
    repeat (5) @(negedge clk_i);
    enable_i = 1'b1;
    check_eq("en_level", 32'(level_o), 32'd1);
    drain_check();

    // Asynchronous reset mid-frame
    send8(8'h12);
    @(posedge clk_i); #1;
    rx_i = 1'b0;
    repeat (40) @(posedge clk_i);
    @(negedge clk_i);
    busy = idle_o ? 32'd0 : 32'd1;
    check_eq("mid_busy", busy, 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_vals();
    rx_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.delete();
    check_quiet("post_rst_quiet");
    send8(8'h3E);
    drain_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
